// File: rtl/icsc_csc_coef_ctrl.sv
// Double-buffered colour-space-conversion coefficient bank: software fills the shadow bank,
// and a commit copies it into the active bank atomically on the next vsync rising edge.
module icsc_csc_coef_ctrl #(
   parameter int COEF_WIDTH = 10,
   parameter int BIAS_WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         i_vs,
   input  logic                         i_wr_en,
   input  logic [3:0]                   i_wr_addr,
   input  logic [COEF_WIDTH-1:0]        i_wr_data,
   input  logic                         i_commit,
   output logic                         o_busy,
   output logic                         o_wr_err,
   output logic signed [COEF_WIDTH-1:0] o_coef00,
   output logic signed [COEF_WIDTH-1:0] o_coef01,
   output logic signed [COEF_WIDTH-1:0] o_coef02,
   output logic signed [COEF_WIDTH-1:0] o_coef10,
   output logic signed [COEF_WIDTH-1:0] o_coef11,
   output logic signed [COEF_WIDTH-1:0] o_coef12,
   output logic signed [COEF_WIDTH-1:0] o_coef20,
   output logic signed [COEF_WIDTH-1:0] o_coef21,
   output logic signed [COEF_WIDTH-1:0] o_coef22,
   output logic signed [BIAS_WIDTH-1:0] o_bias0,
   output logic signed [BIAS_WIDTH-1:0] o_bias1,
   output logic signed [BIAS_WIDTH-1:0] o_bias2,
   output logic                         o_bypass,
   output logic                         o_update,
   output logic [7:0]                   o_upd_cnt
);

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } state_t;

   state_t state;
   logic   vs_q;
   logic   vs_rise;

   logic signed [COEF_WIDTH-1:0] sh_coef  [9];
   logic signed [COEF_WIDTH-1:0] act_coef [9];
   logic signed [BIAS_WIDTH-1:0] sh_bias  [3];
   logic signed [BIAS_WIDTH-1:0] act_bias [3];
   logic                         sh_bypass;
   logic                         act_bypass;

   assign vs_rise = i_vs & ~vs_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         vs_q       <= 1'b0;
         o_busy     <= 1'b0;
         o_wr_err   <= 1'b0;
         o_update   <= 1'b0;
         o_upd_cnt  <= 8'd0;
         // NOTE: both banks are a handful of flops, not RAM, so every entry gets a reset value.
         for (int k = 0; k < 9; k++) begin
            sh_coef[k]  <= '0;
            act_coef[k] <= '0;
         end
         for (int k = 0; k < 3; k++) begin
            sh_bias[k]  <= '0;
            act_bias[k] <= '0;
         end
         sh_bypass  <= 1'b1;
         act_bypass <= 1'b1;
      end else begin
         // NOTE: non-blocking everywhere here so every register sees the pre-edge values.
         vs_q     <= i_vs;
         o_update <= 1'b0;
         o_wr_err <= 1'b0;
         case (state)
            IDLE: begin
               if (i_wr_en) begin
                  case (i_wr_addr)
                     4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
                     4'd5, 4'd6, 4'd7, 4'd8: sh_coef[i_wr_addr] <= i_wr_data;
                     4'd9:  sh_bias[0] <= i_wr_data[BIAS_WIDTH-1:0];
                     4'd10: sh_bias[1] <= i_wr_data[BIAS_WIDTH-1:0];
                     4'd11: sh_bias[2] <= i_wr_data[BIAS_WIDTH-1:0];
                     4'd12: sh_bypass  <= i_wr_data[0];
                     default: ;  // reserved addresses are silently dropped
                  endcase
               end
               // a vsync edge coinciding with the commit only arms; the swap waits for the next edge
               if (i_commit) begin
                  state  <= PEND;
                  o_busy <= 1'b1;
               end
            end
            PEND: begin
               o_wr_err <= i_wr_en | i_commit;
               if (vs_rise) begin
                  act_coef   <= sh_coef;
                  act_bias   <= sh_bias;
                  act_bypass <= sh_bypass;
                  state      <= IDLE;
                  o_busy     <= 1'b0;
                  o_update   <= 1'b1;
                  o_upd_cnt  <= o_upd_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign o_coef00 = act_coef[0];
   assign o_coef01 = act_coef[1];
   assign o_coef02 = act_coef[2];
   assign o_coef10 = act_coef[3];
   assign o_coef11 = act_coef[4];
   assign o_coef12 = act_coef[5];
   assign o_coef20 = act_coef[6];
   assign o_coef21 = act_coef[7];
   assign o_coef22 = act_coef[8];
   assign o_bias0  = act_bias[0];
   assign o_bias1  = act_bias[1];
   assign o_bias2  = act_bias[2];
   assign o_bypass = act_bypass;

endmodule

// File: tb/tb_icsc_csc_coef_ctrl.sv
// Bench for icsc_csc_coef_ctrl: a bank-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_icsc_csc_coef_ctrl;

   localparam int CW = 10;
   localparam int BW = 8;

   logic                 clk;
   logic                 rstn;
   logic                 i_vs;
   logic                 i_wr_en;
   logic [3:0]           i_wr_addr;
   logic [CW-1:0]        i_wr_data;
   logic                 i_commit;
   logic                 o_busy;
   logic                 o_wr_err;
   logic signed [CW-1:0] o_coef00, o_coef01, o_coef02, o_coef10, o_coef11;
   logic signed [CW-1:0] o_coef12, o_coef20, o_coef21, o_coef22;
   logic signed [BW-1:0] o_bias0, o_bias1, o_bias2;
   logic                 o_bypass;
   logic                 o_update;
   logic [7:0]           o_upd_cnt;

   int n_cmp = 0;
   int n_err = 0;

   icsc_csc_coef_ctrl #(.COEF_WIDTH(CW), .BIAS_WIDTH(BW)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .i_vs      (i_vs),
      .i_wr_en   (i_wr_en),
      .i_wr_addr (i_wr_addr),
      .i_wr_data (i_wr_data),
      .i_commit  (i_commit),
      .o_busy    (o_busy),
      .o_wr_err  (o_wr_err),
      .o_coef00  (o_coef00),
      .o_coef01  (o_coef01),
      .o_coef02  (o_coef02),
      .o_coef10  (o_coef10),
      .o_coef11  (o_coef11),
      .o_coef12  (o_coef12),
      .o_coef20  (o_coef20),
      .o_coef21  (o_coef21),
      .o_coef22  (o_coef22),
      .o_bias0   (o_bias0),
      .o_bias1   (o_bias1),
      .o_bias2   (o_bias2),
      .o_bypass  (o_bypass),
      .o_update  (o_update),
      .o_upd_cnt (o_upd_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic signed [CW-1:0] d_coef [9];
   logic signed [BW-1:0] d_bias [3];
   assign d_coef[0] = o_coef00;
   assign d_coef[1] = o_coef01;
   assign d_coef[2] = o_coef02;
   assign d_coef[3] = o_coef10;
   assign d_coef[4] = o_coef11;
   assign d_coef[5] = o_coef12;
   assign d_coef[6] = o_coef20;
   assign d_coef[7] = o_coef21;
   assign d_coef[8] = o_coef22;
   assign d_bias[0] = o_bias0;
   assign d_bias[1] = o_bias1;
   assign d_bias[2] = o_bias2;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: what the outputs must show after each clock edge.
   logic signed [CW-1:0] m_sh_coef [9];
   logic signed [CW-1:0] m_act_coef [9];
   logic signed [BW-1:0] m_sh_bias [3];
   logic signed [BW-1:0] m_act_bias [3];
   logic m_sh_byp, m_act_byp, m_pend, m_err, m_upd, m_vs_prev;
   int   m_cnt;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < 9; k++) begin
            m_sh_coef[k]  = '0;
            m_act_coef[k] = '0;
         end
         for (int k = 0; k < 3; k++) begin
            m_sh_bias[k]  = '0;
            m_act_bias[k] = '0;
         end
         m_sh_byp = 1'b1; m_act_byp = 1'b1;
         m_pend = 1'b0; m_err = 1'b0; m_upd = 1'b0; m_vs_prev = 1'b0; m_cnt = 0;
      end else begin
         automatic bit rise = i_vs && !m_vs_prev;
         automatic int a = int'(i_wr_addr);
         m_vs_prev = i_vs;
         m_upd = 1'b0;
         m_err = m_pend && (i_wr_en || i_commit);
         if (!m_pend) begin
            if (i_wr_en) begin
               if (a < 9)       m_sh_coef[4'(a)] = i_wr_data;
               else if (a < 12) m_sh_bias[2'(a - 9)] = i_wr_data[BW-1:0];
               else if (a == 12) m_sh_byp = i_wr_data[0];
            end
            if (i_commit) m_pend = 1'b1;
         end else if (rise) begin
            m_act_coef = m_sh_coef;
            m_act_bias = m_sh_bias;
            m_act_byp  = m_sh_byp;
            m_pend     = 1'b0;
            m_upd      = 1'b1;
            m_cnt      = (m_cnt + 1) % 256;
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      check("busy", int'(o_busy), int'(m_pend));
      check("wr_err", int'(o_wr_err), int'(m_err));
      check("update", int'(o_update), int'(m_upd));
      check("upd_cnt", int'(o_upd_cnt), m_cnt);
      check("bypass", int'(o_bypass), int'(m_act_byp));
      for (int k = 0; k < 9; k++) check($sformatf("coef[%0d]", k), int'(d_coef[k]), int'(m_act_coef[k]));
      for (int k = 0; k < 3; k++) check($sformatf("bias[%0d]", k), int'(d_bias[k]), int'(m_act_bias[k]));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int addr, input int data);
      i_wr_en = 1'b1; i_wr_addr = 4'(addr); i_wr_data = CW'(data);
      tick();
      i_wr_en = 1'b0;
   endtask

   task automatic commit();
      i_commit = 1'b1;
      tick();
      i_commit = 1'b0;
   endtask

   task automatic vs_pulse();
      i_vs = 1'b1;
      tick();
      tick();
      i_vs = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      repeat (2) tick();
      rstn = 1'b1;
      tick();
   endtask

   initial begin
      rstn = 1'b0; i_vs = 1'b0; i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0; i_commit = 1'b0;
      repeat (3) tick();
      rstn = 1'b1;
      tick();

      // defaults after reset
      for (int k = 0; k < 9; k++) check("rst_coef", int'(d_coef[k]), 0);
      for (int k = 0; k < 3; k++) check("rst_bias", int'(d_bias[k]), 0);
      check("rst_bypass", int'(o_bypass), 1);
      check("rst_cnt", int'(o_upd_cnt), 0);
      check("rst_busy", int'(o_busy), 0);

      // basic commit then vsync
      wr(0, 256); wr(4, -100); wr(9, -16); wr(12, 0);
      commit();
      check("pend_busy", int'(o_busy), 1);
      check("pend_coef00", int'(o_coef00), 0);
      check("pend_bypass", int'(o_bypass), 1);
      i_vs = 1'b1;
      tick();
      check("swap_coef00", int'(o_coef00), 256);
      check("swap_coef11", int'(o_coef11), -100);
      check("swap_bias0", int'(o_bias0), -16);
      check("swap_bypass", int'(o_bypass), 0);
      check("swap_update", int'(o_update), 1);
      check("swap_cnt", int'(o_upd_cnt), 1);
      check("swap_busy", int'(o_busy), 0);
      tick();
      check("update_once", int'(o_update), 0);
      i_vs = 1'b0;
      tick();

      // vsync while idle does nothing; reserved address write is silent
      vs_pulse();
      check("idle_vs_cnt", int'(o_upd_cnt), 1);
      wr(13, 5);
      check("reserved_err", int'(o_wr_err), 0);

      // write during pending commit is rejected
      wr(1, 5);
      commit();
      wr(1, 77);
      check("pend_wr_err", int'(o_wr_err), 1);
      tick();
      check("pend_wr_err_pulse", int'(o_wr_err), 0);
      vs_pulse();
      check("pend_wr_coef01", int'(o_coef01), 5);
      check("pend_wr_cnt", int'(o_upd_cnt), 2);

      // write and commit in the same cycle both land
      i_wr_en = 1'b1; i_wr_addr = 4'd3; i_wr_data = CW'(9); i_commit = 1'b1;
      tick();
      i_wr_en = 1'b0; i_commit = 1'b0;
      check("wc_busy", int'(o_busy), 1);
      vs_pulse();
      check("wc_coef10", int'(o_coef10), 9);
      check("wc_cnt", int'(o_upd_cnt), 3);

      // commit coinciding with a vsync rise waits for the next rise
      wr(2, 33);
      i_commit = 1'b1; i_vs = 1'b1;
      tick();
      i_commit = 1'b0;
      check("coin_busy", int'(o_busy), 1);
      check("coin_cnt", int'(o_upd_cnt), 3);
      check("coin_coef02", int'(o_coef02), 0);
      tick();
      i_vs = 1'b0;
      tick();
      i_vs = 1'b1;
      tick();
      check("coin_coef02_after", int'(o_coef02), 33);
      check("coin_cnt_after", int'(o_upd_cnt), 4);
      i_vs = 1'b0;
      tick();

      // commit in the swap cycle is rejected
      commit();
      i_vs = 1'b1; i_commit = 1'b1;
      tick();
      i_commit = 1'b0;
      check("swapcyc_err", int'(o_wr_err), 1);
      check("swapcyc_busy", int'(o_busy), 0);
      check("swapcyc_cnt", int'(o_upd_cnt), 5);
      i_vs = 1'b0;
      tick();

      // reset while pending discards the commit
      wr(0, 11);
      commit();
      rstn = 1'b0;
      #1;
      check("rst_pend_busy", int'(o_busy), 0);
      check("rst_pend_cnt", int'(o_upd_cnt), 0);
      tick();
      rstn = 1'b1;
      tick();
      vs_pulse();
      check("rst_pend_cnt_after", int'(o_upd_cnt), 0);
      check("rst_pend_coef00", int'(o_coef00), 0);
      check("rst_pend_bypass", int'(o_bypass), 1);

      // vsync held high across reset release, commit on the first cycle
      rstn = 1'b0; i_vs = 1'b1;
      tick();
      rstn = 1'b1; i_commit = 1'b1;
      tick();
      i_commit = 1'b0;
      tick();
      check("vs_high_busy", int'(o_busy), 1);
      check("vs_high_cnt", int'(o_upd_cnt), 0);
      i_vs = 1'b0;
      tick();
      i_vs = 1'b1;
      tick();
      check("vs_high_cnt_after", int'(o_upd_cnt), 1);
      i_vs = 1'b0;
      tick();

      // counter wrap
      do_reset();
      for (int n = 0; n < 255; n++) begin
         commit();
         vs_pulse();
      end
      check("cnt_255", int'(o_upd_cnt), 255);
      commit();
      vs_pulse();
      check("cnt_wrap", int'(o_upd_cnt), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
